// File: rtl/ccd_sharp_htiming.sv
// ---------------------------------------------------------------------------
// ccd_sharp_htiming
// Horizontal readout timing generator for the Sharp CCD simulation path.
// Drives the horizontal shift-register model (frame/line change, hl, h1, h2,
// rs) and tells downstream capture models when the shifted pixel is stable.
//
// Sequence: IDLE -> FCHG -> LCHG -> HGAP -> SHIFT -> HBLANK -> (LCHG|FCHG|IDLE)
//
// Optional feature macro: CCD_SHARP_HTIMING_FRAME_CHANGE_EN
//   defined   : a FCHG phase (o_frame_change pulse) opens every frame
//   undefined : no FCHG phase, frames open directly with LCHG and
//               o_frame_change is tied low
//
// Ports
//   clk            in   timing clock
//   reset_n        in   asynchronous active-low reset
//   i_start        in   level; high = run frames continuously
//   o_frame_change out  frame transfer pulse to the shift model
//   o_line_change  out  vertical-to-horizontal transfer pulse
//   hl             out  last-stage horizontal clock (shift on rising edge)
//   h1             out  horizontal clock phase 1
//   h2             out  horizontal clock phase 2 (complement of h1 in SHIFT)
//   rs             out  reset gate, high for the first clk of each pixel
//   o_pix_valid    out  one-clk strobe on the last clk of each pixel
//   ov_pix_cnt     out  pixel index within the line
//   ov_line_cnt    out  line index within the frame
//
// All outputs are flops decoded from the current state, so every output
// follows the state register by exactly one clk and cannot glitch.
// ---------------------------------------------------------------------------
module ccd_sharp_htiming #(
    parameter int unsigned ALLPIX_PER_LINE   = 1376,
    parameter int unsigned PIX_CLKS          = 4,
    parameter int unsigned LINE_CHANGE_CLKS  = 2,
    parameter int unsigned FRAME_CHANGE_CLKS = 3,
    parameter int unsigned HGAP_CLKS         = 2,
    parameter int unsigned HBLANK_CLKS       = 8,
    parameter int unsigned LINES_PER_FRAME   = 1050
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    output logic        o_frame_change,
    output logic        o_line_change,
    output logic        hl,
    output logic        h1,
    output logic        h2,
    output logic        rs,
    output logic        o_pix_valid,
    output logic [15:0] ov_pix_cnt,
    output logic [15:0] ov_line_cnt
);

    // Dwell counter is shared by all fixed-length non-SHIFT phases.
    localparam int unsigned DWELL_A   = (FRAME_CHANGE_CLKS > LINE_CHANGE_CLKS) ?
                                        FRAME_CHANGE_CLKS : LINE_CHANGE_CLKS;
    localparam int unsigned DWELL_B   = (HGAP_CLKS > HBLANK_CLKS) ? HGAP_CLKS : HBLANK_CLKS;
    localparam int unsigned DWELL_MAX = (DWELL_A > DWELL_B) ? DWELL_A : DWELL_B;
    localparam int unsigned CNT_W     = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam int unsigned PH_W      = $clog2(PIX_CLKS);
    localparam int unsigned HALF      = PIX_CLKS / 2;
    localparam int unsigned IDX_W     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FCHG   = 3'd1,
        LCHG   = 3'd2,
        HGAP   = 3'd3,
        SHIFT  = 3'd4,
        HBLANK = 3'd5
    } state_t;

    // First state of every frame.
`ifdef CCD_SHARP_HTIMING_FRAME_CHANGE_EN
    localparam state_t FRAME_START = FCHG;
`else
    localparam state_t FRAME_START = LCHG;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [IDX_W-1:0]   pix_q,   pix_d;
    logic [IDX_W-1:0]   line_q,  line_d;

    logic               line_change_q, line_change_d;
    logic               hl_q,          hl_d;
    logic               h2_q,          h2_d;
    logic               rs_q,          rs_d;
    logic               pix_valid_q,   pix_valid_d;
    logic [IDX_W-1:0]   pix_cnt_q;
    logic [IDX_W-1:0]   line_cnt_q;

    // State and sequencing counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            pix_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        pix_d   = pix_q;
        line_d  = line_q;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                phase_d = '0;
                pix_d   = '0;
                line_d  = '0;
                if (i_start) begin
                    state_d = FRAME_START;
                end
            end

`ifdef CCD_SHARP_HTIMING_FRAME_CHANGE_EN
            FCHG: begin
                if (cnt_q == CNT_W'(FRAME_CHANGE_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = LCHG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            LCHG: begin
                if (cnt_q == CNT_W'(LINE_CHANGE_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = HGAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HGAP: begin
                if (cnt_q == CNT_W'(HGAP_CLKS - 1)) begin
                    cnt_d   = '0;
                    phase_d = '0;
                    pix_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Pixel index advances on phase wrap; it returns to zero when
            // the last pixel completes so it never exceeds its bound.
            SHIFT: begin
                if (phase_q == PH_W'(PIX_CLKS - 1)) begin
                    phase_d = '0;
                    if (pix_q == IDX_W'(ALLPIX_PER_LINE - 1)) begin
                        pix_d   = '0;
                        cnt_d   = '0;
                        state_d = HBLANK;
                    end else begin
                        pix_d = pix_q + IDX_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            // i_start is only consulted here at frame end and in IDLE.
            HBLANK: begin
                if (cnt_q == CNT_W'(HBLANK_CLKS - 1)) begin
                    cnt_d = '0;
                    if (line_q < IDX_W'(LINES_PER_FRAME - 1)) begin
                        line_d  = line_q + IDX_W'(1);
                        state_d = LCHG;
                    end else begin
                        line_d  = '0;
                        state_d = i_start ? FRAME_START : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                phase_d = '0;
                pix_d   = '0;
                line_d  = '0;
            end
        endcase
    end

    // Output decode from the current state; registered below.
    always_comb begin
        line_change_d = 1'b0;
        hl_d          = 1'b0;
        h2_d          = 1'b0;
        rs_d          = 1'b0;
        pix_valid_d   = 1'b0;

        if (state_q == LCHG) begin
            line_change_d = 1'b1;
        end
        if (state_q == SHIFT) begin
            hl_d        = (phase_q <  PH_W'(HALF));
            h2_d        = (phase_q >= PH_W'(HALF));
            rs_d        = (phase_q == '0);
            pix_valid_d = (phase_q == PH_W'(PIX_CLKS - 1));
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_change_q <= 1'b0;
            hl_q          <= 1'b0;
            h2_q          <= 1'b0;
            rs_q          <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
        end else begin
            line_change_q <= line_change_d;
            hl_q          <= hl_d;
            h2_q          <= h2_d;
            rs_q          <= rs_d;
            pix_valid_q   <= pix_valid_d;
            pix_cnt_q     <= pix_q;
            line_cnt_q    <= line_q;
        end
    end

`ifdef CCD_SHARP_HTIMING_FRAME_CHANGE_EN
    logic frame_change_q;

    // Frame change pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_change_q <= 1'b0;
        end else begin
            frame_change_q <= (state_q == FCHG);
        end
    end

    assign o_frame_change = frame_change_q;
`else
    assign o_frame_change = 1'b0;
`endif

    // hl and h1 share one flop: they are identical by definition.
    assign o_line_change = line_change_q;
    assign hl            = hl_q;
    assign h1            = hl_q;
    assign h2            = h2_q;
    assign rs            = rs_q;
    assign o_pix_valid   = pix_valid_q;
    assign ov_pix_cnt    = pix_cnt_q;
    assign ov_line_cnt   = line_cnt_q;

endmodule

// File: tb/tb_ccd_sharp_htiming.sv
// Testbench for ccd_sharp_htiming. Expected outputs come from a frame
// position model: each frame is a flat timeline of clks, and every output
// is computed from the position in that timeline with plain arithmetic.
module tb_ccd_sharp_htiming;

    localparam int ALLPIX = 8;
    localparam int PIXC   = 4;
    localparam int LCH    = 2;
    localparam int FCH    = 3;
    localparam int HGAP   = 2;
    localparam int HBL    = 5;
    localparam int LINES  = 3;
`ifdef CCD_SHARP_HTIMING_FRAME_CHANGE_EN
    localparam int FEN    = 1;
`else
    localparam int FEN    = 0;
`endif
    localparam int FL        = FEN ? FCH : 0;
    localparam int LP        = LCH + HGAP + ALLPIX * PIXC + HBL;
    localparam int FRAME_LEN = FL + LINES * LP;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_frame_change, o_line_change, hl, h1, h2, rs, o_pix_valid;
    logic [15:0] ov_pix_cnt, ov_line_cnt;
    logic [38:0] act;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ccd_sharp_htiming #(
        .ALLPIX_PER_LINE   (ALLPIX),
        .PIX_CLKS          (PIXC),
        .LINE_CHANGE_CLKS  (LCH),
        .FRAME_CHANGE_CLKS (FCH),
        .HGAP_CLKS         (HGAP),
        .HBLANK_CLKS       (HBL),
        .LINES_PER_FRAME   (LINES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_start        (i_start),
        .o_frame_change (o_frame_change),
        .o_line_change  (o_line_change),
        .hl             (hl),
        .h1             (h1),
        .h2             (h2),
        .rs             (rs),
        .o_pix_valid    (o_pix_valid),
        .ov_pix_cnt     (ov_pix_cnt),
        .ov_line_cnt    (ov_line_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {o_frame_change, o_line_change, hl, h1, h2, rs, o_pix_valid,
                  ov_pix_cnt, ov_line_cnt};

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Outputs at frame position t (t < 0 means idle).
    function automatic logic [38:0] expect_of(input int t);
        logic f, l, a, b, r, v;
        int   line, pix, u, o, s, p;
        f = 0; l = 0; a = 0; b = 0; r = 0; v = 0; line = 0; pix = 0;
        if (t >= 0) begin
            if (t < FL) begin
                f = 1;
            end else begin
                u    = t - FL;
                line = u / LP;
                o    = u % LP;
                l    = (o < LCH);
                if (o >= LCH + HGAP && o < LCH + HGAP + ALLPIX * PIXC) begin
                    s   = o - LCH - HGAP;
                    pix = s / PIXC;
                    p   = s % PIXC;
                    a   = (p < PIXC / 2);
                    b   = !a;
                    r   = (p == 0);
                    v   = (p == PIXC - 1);
                end
            end
        end
        return {f, l, a, a, b, r, v, 16'(pix), 16'(line)};
    endfunction

    // Reference model: frame position advanced per clk; outputs lag by one.
    int          pos   = -1;
    logic [38:0] exp_v = '0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos   = -1;
            exp_v = '0;
        end else begin
            exp_v = expect_of(pos);
            if (pos < 0 || pos == FRAME_LEN - 1) pos = i_start ? 0 : -1;
            else                                 pos = pos + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare cyc %0d: got %h expected %h", cyc, act, exp_v);
            end
        end
    end

    // Line-level properties from the specification, as literal numbers.
    logic hl_prev = 0, lc_prev = 0;
    int   hl_cnt = 0, rs_cnt = 0, v_cnt = 0;
    int   last_lc = 0, last_line = 0, last_l0 = 0;
    bit   line_ok = 0, start_ok = 0, l0_ok = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            line_ok = 0; l0_ok = 0; hl_prev = 0; lc_prev = 0;
        end else begin
            if (!i_start) begin
                start_ok = 0; l0_ok = 0;
            end
            if (hl && !hl_prev) hl_cnt++;
            if (rs)             rs_cnt++;
            if (o_pix_valid)    v_cnt++;
            if (o_line_change && !lc_prev) begin
                if (line_ok) begin
                    check("hl_rises_per_line", hl_cnt, 8);
                    check("rs_pulses_per_line", rs_cnt, 8);
                    check("valid_per_line", v_cnt, 8);
                    if (int'(ov_line_cnt) == last_line + 1) begin
                        check("line_period", cyc - last_lc, 41);
                    end else if (ov_line_cnt == 16'd0 && last_line == 2) begin
                        if (start_ok) check("frame_wrap_period", cyc - last_lc, FEN ? 44 : 41);
                    end else begin
                        check("line_sequence", ov_line_cnt, (last_line + 1) % 3);
                    end
                end
                if (ov_line_cnt == 16'd0) begin
                    if (l0_ok) check("frame_period", cyc - last_l0, FEN ? 126 : 123);
                    l0_ok   = 1;
                    last_l0 = cyc;
                end
                line_ok   = 1;
                start_ok  = 1;
                last_line = int'(ov_line_cnt);
                last_lc   = cyc;
                hl_cnt = 0; rs_cnt = 0; v_cnt = 0;
            end
            hl_prev = hl;
            lc_prev = o_line_change;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return o_frame_change;
            1:       return o_line_change;
            2:       return hl;
            3:       return ov_line_cnt == 16'd1;
            default: return h1 && ov_pix_cnt == 16'd4;
        endcase
    endfunction

    // Bounded wait; records the cycle at which the signal is seen high.
    task automatic wait_sig(input int which, input string name, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: got timeout expected event", name);
        end
        #1;
    endtask

    task automatic start_and_check(input string tag);
        int c0, t;
        i_start = 1'b1;
        c0      = cyc;
        if (FEN != 0) begin
            wait_sig(0, {tag, "_fchg"}, t);
            if (t >= 0) check({tag, "_fchg_delay"}, t - c0, 2);
        end
        wait_sig(1, {tag, "_lchg"}, t);
        if (t >= 0) check({tag, "_lchg_delay"}, t - c0, FEN ? 5 : 2);
        check({tag, "_first_line"}, ov_line_cnt, 0);
        wait_sig(2, {tag, "_hl"}, t);
        if (t >= 0) check({tag, "_hl_delay"}, t - c0, FEN ? 9 : 6);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        repeat (3) step();
        check("reset_outputs", act, 0);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle_outputs", act, 0);

        // Start, then continuous run over several frames.
        start_and_check("start");
        repeat (2 * FRAME_LEN + 20) step();

        // Drop i_start during line 1: frame completes, then idle.
        wait_sig(3, "line1", t);
        i_start = 1'b0;
        repeat (FRAME_LEN) step();
        check("idle_after_stop", act, 0);
        repeat (10) step();
        check("still_idle", act, 0);
        start_and_check("restart");

        // Asynchronous reset in the middle of pixel 4.
        wait_sig(4, "pixel4", t);
        #2 reset_n = 1'b0;
        #1 check("async_reset", act, 0);
        step();
        step();
        reset_n = 1'b1;
        start_and_check("post_reset");
        repeat (FRAME_LEN) step();

        // Random run/stop and reset activity.
        for (int i = 0; i < 5000; i++) begin
            step();
            if ($urandom_range(0, 149) == 0) i_start = ~i_start;
            if ($urandom_range(0, 1999) == 0) begin
                reset_n = 1'b0;
                step();
                step();
                reset_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_sharp_htiming.md
Name: ccd_sharp_htiming

Overview:
Horizontal readout timing generator for the Sharp CCD simulation path. It sits directly upstream of the horizontal shift-register model and drives its line-change, frame-change, hl, h1, h2 and rs inputs. It also produces a sample strobe and pixel and line counters, so downstream AFE/capture models know when the shift-register output is stable. All outputs are registered and free of glitches.

Parameters:
ALLPIX_PER_LINE, 1376, hl pulses per line (dummy + black + image + black + dummy), >=2
PIX_CLKS, 4, clk cycles per pixel period; even, >=4
LINE_CHANGE_CLKS, 2, width of o_line_change pulse in clks, >=1
FRAME_CHANGE_CLKS, 3, width of o_frame_change pulse in clks, >=1
HGAP_CLKS, 2, idle clks between end of line change and first pixel, >=1
HBLANK_CLKS, 8, idle clks after last pixel, >=1
LINES_PER_FRAME, 1050, lines per frame, >=1

Ports:
clk  input  1  timing clock
reset_n  input  1  asynchronous active-low reset
i_start  input  1  level; high = run frames continuously
o_frame_change  output  1  frame transfer pulse to shift model
o_line_change  output  1  vertical-to-horizontal transfer pulse
hl  output  1  last-stage horizontal clock (shift edge = rising)
h1  output  1  horizontal clock phase 1
h2  output  1  horizontal clock phase 2 (complement of h1 during SHIFT)
rs  output  1  reset gate; output data is forced to zero while high
o_pix_valid  output  1  one-clk strobe; shift-model output is stable
ov_pix_cnt  output  16  index of current pixel in line (0..ALLPIX_PER_LINE-1)
ov_line_cnt  output  16  index of current line in frame (0..LINES_PER_FRAME-1)

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; counters 0. Reset mid-line aborts immediately. No partial pulse remains.
- States: IDLE -> FCHG -> LCHG -> HGAP -> SHIFT -> HBLANK -> (LCHG | FCHG | IDLE).
- IDLE: all outputs 0. When i_start is sampled high, the next state is FCHG. o_frame_change rises at the clk edge after the sampling edge.
- FCHG: o_frame_change=1 for exactly FRAME_CHANGE_CLKS clks, then LCHG.
- LCHG: o_line_change=1 for exactly LINE_CHANGE_CLKS clks, then HGAP.
- HGAP: all clocks low for HGAP_CLKS clks, then SHIFT.
- SHIFT: lasts ALLPIX_PER_LINE*PIX_CLKS clks. Phase counter p runs 0..PIX_CLKS-1 per pixel.
  - hl=h1=1 for p<PIX_CLKS/2; h2=!h1.
  - rs=1 only at p=0.
  - o_pix_valid=1 only at p=PIX_CLKS-1.
  - ov_pix_cnt increments at the wrap of p and holds its value through the pixel.
- HBLANK: h1/h2/hl/rs=0 for HBLANK_CLKS clks. At the end:
  - If ov_line_cnt<LINES_PER_FRAME-1: line_cnt+1, go to LCHG.
  - Else: line_cnt=0. Go to FCHG if i_start=1, otherwise IDLE.
- i_start is only checked in IDLE and at the frame end. Deasserting it mid-frame still completes the frame.
- Line period = LINE_CHANGE_CLKS+HGAP_CLKS+ALLPIX_PER_LINE*PIX_CLKS+HBLANK_CLKS. The first line of each frame adds FRAME_CHANGE_CLKS.
- o_frame_change and o_line_change never overlap. hl never toggles while either pulse is high.
- The total number of hl rising edges per line is exactly ALLPIX_PER_LINE.
- Counters wrap only at the stated bounds. Values never exceed param-1.

Optional Feature:
Macro CCD_SHARP_HTIMING_FRAME_CHANGE_EN.
- Defined: behaviour as above.
- Undefined:
  - FCHG state is removed: IDLE and frame end go directly to LCHG.
  - o_frame_change is tied to 0.
  - Frame period shrinks by FRAME_CHANGE_CLKS.
  - ov_line_cnt still wraps at LINES_PER_FRAME.

Test Plan:
Params for all tests: ALLPIX=8, PIX_CLKS=4, LCHG=2, FCHG=3, HGAP=2, HBLANK=5, LINES=3; macro defined.
1. Reset release, i_start=1 -> o_frame_change high 3 clks, then o_line_change high 2 clks; first hl rise 2 clks later.
2. One line -> exactly 8 hl rises; 8 o_pix_valid strobes at p=3; ov_pix_cnt 0..7; rs high 1 clk per pixel; h2==!h1 throughout SHIFT.
3. Continuous run -> line period 41 clks; frame period 126 clks; ov_line_cnt sequence 0,1,2,0; o_frame_change only before line 0.
4. i_start dropped during line 1 -> lines 1 and 2 complete, then IDLE with all outputs 0; reassert -> restart at FCHG with line 0.
5. reset_n pulsed low mid-SHIFT (pixel 4) -> all outputs 0 asynchronously; after release with i_start=1, a clean frame restarts from FCHG.
6. Macro undefined -> o_frame_change constantly 0; frame period 123 clks; 8 hl rises per line unchanged.
